// File: rtl/mem_access_stage.sv
// Memory-access / writeback stage behind the execute ALU: one transaction at a time,
// single-outstanding data-memory request with a cycle timeout, then a one-cycle register write.
//
// state  | meaning
// IDLE   | ready for a new transaction from execute
// ACCESS | memory request outstanding, waiting for ack or timeout
// WB     | register-file write strobe cycle
module mem_access_stage #(
   parameter int DATA_W      = 32,
   parameter int ADDR_W      = 16,
   parameter int MEM_TIMEOUT = 15
) (
   input  logic              clock,
   input  logic              reset_n,
   input  logic              ex_valid,
   output logic              ex_ready,
   input  logic [1:0]        ex_op,
   input  logic [DATA_W-1:0] alu_result,
   input  logic [DATA_W-1:0] store_data,
   input  logic [4:0]        ex_rd,
   output logic              mem_req,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata,
   input  logic              mem_ack,
   output logic              wb_en,
   output logic [4:0]        wb_rd,
   output logic [DATA_W-1:0] wb_data,
   output logic              mem_err
);

   typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_WB} state_t;

   localparam logic [1:0] OP_ALU   = 2'b00;
   localparam logic [1:0] OP_LOAD  = 2'b01;
   localparam logic [1:0] OP_STORE = 2'b10;
   localparam logic [7:0] TMO_LAST = 8'(MEM_TIMEOUT - 1);

   state_t     state, state_nxt;
   logic [1:0] op_q;
   logic [7:0] tmo_cnt;
   logic       take;
   logic       tmo_hit;

   assign ex_ready = (state == S_IDLE);
   assign take     = ex_valid && ex_ready;
   // An ack in the final allowed cycle takes priority over the timeout.
   assign tmo_hit  = (state == S_ACCESS) && !mem_ack && (tmo_cnt == TMO_LAST);

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) state <= S_IDLE;
      else          state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE: begin
            if (take) begin
               if (ex_op == OP_ALU)                             state_nxt = S_WB;
               else if (ex_op == OP_LOAD || ex_op == OP_STORE)  state_nxt = S_ACCESS;
            end
         end
         S_ACCESS: begin
            if (mem_ack)      state_nxt = (op_q == OP_LOAD) ? S_WB : S_IDLE;
            else if (tmo_hit) state_nxt = S_IDLE;
         end
         S_WB:    state_nxt = S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         op_q      <= OP_ALU;
         tmo_cnt   <= 8'd0;
         mem_req   <= 1'b0;
         mem_we    <= 1'b0;
         mem_addr  <= '0;
         mem_wdata <= '0;
         wb_en     <= 1'b0;
         wb_rd     <= 5'd0;
         wb_data   <= '0;
         mem_err   <= 1'b0;
      end else begin
         wb_en   <= 1'b0;
         mem_err <= 1'b0;
         if (take) begin
            op_q      <= ex_op;
            wb_rd     <= ex_rd;
            mem_addr  <= alu_result[ADDR_W-1:0];
            mem_wdata <= store_data;
            tmo_cnt   <= 8'd0;
            if (ex_op == OP_ALU) begin
               wb_data <= alu_result;
               wb_en   <= (ex_rd != 5'd0);
            end else if (ex_op == OP_LOAD || ex_op == OP_STORE) begin
               mem_req <= 1'b1;
               mem_we  <= (ex_op == OP_STORE);
            end
         end else if (state == S_ACCESS) begin
            if (mem_ack) begin
               mem_req <= 1'b0;
               mem_we  <= 1'b0;
               if (op_q == OP_LOAD) begin
                  wb_data <= mem_rdata;
                  wb_en   <= (wb_rd != 5'd0);
               end
            end else if (tmo_hit) begin
               mem_req <= 1'b0;
               mem_we  <= 1'b0;
               mem_err <= 1'b1;
            end else begin
               tmo_cnt <= tmo_cnt + 8'd1;
            end
         end
      end
   end

endmodule

// File: tb/tb_mem_access_stage.sv
// Directed bench for mem_access_stage: ALU writeback, load/store handshakes,
// timeout abort, backpressure and asynchronous reset abort.
module tb_mem_access_stage;

   logic        clock = 1'b0;
   logic        reset_n;
   logic        ex_valid;
   logic        ex_ready;
   logic [1:0]  ex_op;
   logic [31:0] alu_result;
   logic [31:0] store_data;
   logic [4:0]  ex_rd;
   logic        mem_req;
   logic        mem_we;
   logic [15:0] mem_addr;
   logic [31:0] mem_wdata;
   logic [31:0] mem_rdata;
   logic        mem_ack;
   logic        wb_en;
   logic [4:0]  wb_rd;
   logic [31:0] wb_data;
   logic        mem_err;

   int errors = 0;
   int checks = 0;

   mem_access_stage #(.DATA_W(32), .ADDR_W(16), .MEM_TIMEOUT(15)) dut (
      .clock(clock), .reset_n(reset_n),
      .ex_valid(ex_valid), .ex_ready(ex_ready), .ex_op(ex_op),
      .alu_result(alu_result), .store_data(store_data), .ex_rd(ex_rd),
      .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata), .mem_ack(mem_ack),
      .wb_en(wb_en), .wb_rd(wb_rd), .wb_data(wb_data), .mem_err(mem_err)
   );

   always #5 clock = ~clock;

   // advance one clock edge and settle just past it
   task automatic cycle();
      @(posedge clock);
      #1;
   endtask

   task automatic offer(input logic [1:0] op, input logic [31:0] res,
                        input logic [31:0] sd, input logic [4:0] rd);
      ex_valid = 1'b1; ex_op = op; alu_result = res; store_data = sd; ex_rd = rd;
   endtask

   task automatic test_reset();
      reset_n = 1'b0;
      for (int i = 0; i < 4; i++) begin
         ex_valid = 1'($urandom); ex_op = 2'($urandom); alu_result = $urandom;
         store_data = $urandom; ex_rd = 5'($urandom); mem_rdata = $urandom;
         mem_ack = 1'($urandom);
         cycle();
      end
      checks++; if (ex_ready !== 1'b1) begin errors++; $display("FAIL rst_ex_ready actual=%0h expected=1", ex_ready); end
      checks++; if (mem_req !== 1'b0 || mem_we !== 1'b0) begin errors++; $display("FAIL rst_mem_req_we actual=%0h/%0h expected=0/0", mem_req, mem_we); end
      checks++; if (mem_addr !== 16'h0 || mem_wdata !== 32'h0) begin errors++; $display("FAIL rst_mem_addr_wdata actual=%0h/%0h expected=0/0", mem_addr, mem_wdata); end
      checks++; if (wb_en !== 1'b0 || wb_rd !== 5'd0 || wb_data !== 32'h0 || mem_err !== 1'b0) begin
         errors++; $display("FAIL rst_wb_err actual=%0h/%0h/%0h/%0h expected=0/0/0/0", wb_en, wb_rd, wb_data, mem_err); end
      ex_valid = 1'b0; mem_ack = 1'b0;
      #2 reset_n = 1'b1;
      cycle(); cycle();
      checks++; if (ex_ready !== 1'b1 || mem_req !== 1'b0 || wb_en !== 1'b0 || mem_err !== 1'b0) begin
         errors++; $display("FAIL rst_release actual=%0h/%0h/%0h/%0h expected=1/0/0/0", ex_ready, mem_req, wb_en, mem_err); end
   endtask

   task automatic test_alu_wb();
      offer(2'b00, 32'h0000_002A, 32'h0, 5'd5);
      cycle();
      ex_valid = 1'b0;
      checks++; if (wb_en !== 1'b1 || wb_rd !== 5'd5 || wb_data !== 32'h2A) begin
         errors++; $display("FAIL alu_wb actual=%0h/%0h/%0h expected=1/5/2a", wb_en, wb_rd, wb_data); end
      checks++; if (ex_ready !== 1'b0) begin errors++; $display("FAIL alu_wb_busy actual=%0h expected=0", ex_ready); end
      cycle();
      checks++; if (wb_en !== 1'b0 || ex_ready !== 1'b1) begin
         errors++; $display("FAIL alu_wb_done actual=%0h/%0h expected=0/1", wb_en, ex_ready); end
      // register 0: WB cycle still occurs but no strobe
      offer(2'b00, 32'h0000_0077, 32'h0, 5'd0);
      cycle();
      ex_valid = 1'b0;
      checks++; if (wb_en !== 1'b0 || ex_ready !== 1'b0) begin
         errors++; $display("FAIL alu_rd0 actual=%0h/%0h expected=0/0", wb_en, ex_ready); end
      cycle();
      checks++; if (wb_en !== 1'b0 || ex_ready !== 1'b1) begin
         errors++; $display("FAIL alu_rd0_done actual=%0h/%0h expected=0/1", wb_en, ex_ready); end
   endtask

   task automatic test_noop_and_stray_ack();
      offer(2'b11, 32'h0000_0099, 32'h0, 5'd4);
      mem_ack = 1'b1; mem_rdata = 32'h1111_2222;
      cycle();
      ex_valid = 1'b0; mem_ack = 1'b0;
      checks++; if (ex_ready !== 1'b1 || mem_req !== 1'b0 || wb_en !== 1'b0) begin
         errors++; $display("FAIL noop_drop actual=%0h/%0h/%0h expected=1/0/0", ex_ready, mem_req, wb_en); end
      cycle();
      checks++; if (wb_en !== 1'b0 || mem_err !== 1'b0) begin
         errors++; $display("FAIL stray_ack actual=%0h/%0h expected=0/0", wb_en, mem_err); end
   endtask

   task automatic test_load_wait();
      int req_cycles = 0;
      offer(2'b01, 32'h0000_1234, 32'h0, 5'd3);
      cycle();
      ex_valid = 1'b0;
      checks++; if (mem_addr !== 16'h1234 || mem_we !== 1'b0 || ex_ready !== 1'b0) begin
         errors++; $display("FAIL load_req_fields actual=%0h/%0h/%0h expected=1234/0/0", mem_addr, mem_we, ex_ready); end
      for (int i = 0; i < 3; i++) begin
         if (mem_req === 1'b1) req_cycles++;
         if (i == 2) begin mem_ack = 1'b1; mem_rdata = 32'hDEAD_BEEF; end
         cycle();
      end
      mem_ack = 1'b0; mem_rdata = 32'h0;
      checks++; if (req_cycles != 3 || mem_req !== 1'b0) begin
         errors++; $display("FAIL load_req_len actual=%0d/%0h expected=3/0", req_cycles, mem_req); end
      checks++; if (wb_en !== 1'b1 || wb_rd !== 5'd3 || wb_data !== 32'hDEAD_BEEF) begin
         errors++; $display("FAIL load_wb actual=%0h/%0h/%0h expected=1/3/deadbeef", wb_en, wb_rd, wb_data); end
      cycle();
      checks++; if (wb_en !== 1'b0 || ex_ready !== 1'b1) begin
         errors++; $display("FAIL load_done actual=%0h/%0h expected=0/1", wb_en, ex_ready); end
   endtask

   task automatic test_store();
      offer(2'b10, 32'h0000_0040, 32'h55AA_55AA, 5'd7);
      cycle();
      ex_valid = 1'b0;
      checks++; if (mem_req !== 1'b1 || mem_we !== 1'b1 || mem_addr !== 16'h0040 || mem_wdata !== 32'h55AA_55AA) begin
         errors++; $display("FAIL store_req actual=%0h/%0h/%0h/%0h expected=1/1/40/55aa55aa", mem_req, mem_we, mem_addr, mem_wdata); end
      checks++; if (ex_ready !== 1'b0) begin errors++; $display("FAIL store_busy actual=%0h expected=0", ex_ready); end
      mem_ack = 1'b1;
      cycle();
      mem_ack = 1'b0;
      checks++; if (mem_req !== 1'b0 || ex_ready !== 1'b1 || wb_en !== 1'b0) begin
         errors++; $display("FAIL store_done actual=%0h/%0h/%0h expected=0/1/0", mem_req, ex_ready, wb_en); end
      cycle();
      checks++; if (wb_en !== 1'b0) begin errors++; $display("FAIL store_no_wb actual=%0h expected=0", wb_en); end
   endtask

   task automatic test_timeout();
      int n = 0;
      int bad = 0;
      offer(2'b01, 32'h0000_0200, 32'h0, 5'd6);
      cycle();
      ex_valid = 1'b0;
      while (mem_req === 1'b1 && n < 40) begin
         if (mem_err !== 1'b0 || wb_en !== 1'b0) bad++;
         n++;
         cycle();
      end
      checks++; if (n != 15 || bad != 0) begin
         errors++; $display("FAIL tmo_req_len actual=%0d/%0d expected=15/0", n, bad); end
      checks++; if (mem_err !== 1'b1 || ex_ready !== 1'b1 || wb_en !== 1'b0) begin
         errors++; $display("FAIL tmo_err actual=%0h/%0h/%0h expected=1/1/0", mem_err, ex_ready, wb_en); end
      cycle();
      checks++; if (mem_err !== 1'b0 || wb_en !== 1'b0) begin
         errors++; $display("FAIL tmo_err_pulse actual=%0h/%0h expected=0/0", mem_err, wb_en); end
      // ack in the last allowed cycle wins over the timeout
      offer(2'b01, 32'h0000_0204, 32'h0, 5'd8);
      cycle();
      ex_valid = 1'b0;
      n = 0;
      for (int i = 1; i <= 15; i++) begin
         if (mem_req === 1'b1) n++;
         if (i == 15) begin mem_ack = 1'b1; mem_rdata = 32'hCAFE_0001; end
         cycle();
      end
      mem_ack = 1'b0;
      checks++; if (n != 15 || mem_err !== 1'b0 || wb_en !== 1'b1 || wb_data !== 32'hCAFE_0001) begin
         errors++; $display("FAIL tmo_last_ack actual=%0d/%0h/%0h/%0h expected=15/0/1/cafe0001", n, mem_err, wb_en, wb_data); end
      cycle();
      checks++; if (mem_err !== 1'b0 || ex_ready !== 1'b1) begin
         errors++; $display("FAIL tmo_last_ack_done actual=%0h/%0h expected=0/1", mem_err, ex_ready); end
   endtask

   task automatic test_backpressure_reset();
      int bad = 0;
      offer(2'b01, 32'h0000_0100, 32'h0, 5'd9);
      cycle();
      alu_result = 32'h0000_0300;   // would show up on mem_addr if re-accepted
      for (int i = 0; i < 4; i++) begin
         if (ex_ready !== 1'b0 || mem_req !== 1'b1 || mem_addr !== 16'h0100) bad++;
         cycle();
      end
      checks++; if (bad != 0) begin errors++; $display("FAIL bp_hold actual=%0d expected=0", bad); end
      #2 reset_n = 1'b0;
      #1;
      checks++; if (mem_req !== 1'b0 || wb_en !== 1'b0) begin
         errors++; $display("FAIL rst_async_drop actual=%0h/%0h expected=0/0", mem_req, wb_en); end
      ex_valid = 1'b0;
      mem_ack = 1'b1; mem_rdata = 32'hBAD0_BAD0;
      cycle();
      mem_ack = 1'b0;
      reset_n = 1'b1;
      bad = 0;
      for (int i = 0; i < 5; i++) begin
         cycle();
         if (wb_en !== 1'b0 || mem_req !== 1'b0 || ex_ready !== 1'b1) bad++;
      end
      checks++; if (bad != 0) begin errors++; $display("FAIL rst_no_wb actual=%0d expected=0", bad); end
   endtask

   task automatic test_back_to_back();
      offer(2'b00, 32'h0000_0011, 32'h0, 5'd1);
      cycle();
      offer(2'b00, 32'h0000_0022, 32'h0, 5'd2);   // held during WB, accepted at the next edge
      cycle();
      checks++; if (wb_en !== 1'b0 || ex_ready !== 1'b1) begin
         errors++; $display("FAIL b2b_gap actual=%0h/%0h expected=0/1", wb_en, ex_ready); end
      cycle();
      ex_valid = 1'b0;
      checks++; if (wb_en !== 1'b1 || wb_rd !== 5'd2 || wb_data !== 32'h22) begin
         errors++; $display("FAIL b2b_second actual=%0h/%0h/%0h expected=1/2/22", wb_en, wb_rd, wb_data); end
      cycle();
   endtask

   initial begin
      ex_valid = 1'b0; ex_op = 2'b00; alu_result = '0; store_data = '0; ex_rd = '0;
      mem_rdata = '0; mem_ack = 1'b0; reset_n = 1'b0;
      test_reset();
      test_alu_wb();
      test_noop_and_stray_ack();
      test_load_wait();
      test_store();
      test_timeout();
      test_backpressure_reset();
      test_back_to_back();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/mem_access_stage.md
# mem_access_stage

Memory-access/writeback stage directly downstream of the execute ALU. It latches one ALU result per transaction with its destination register and operation class. Loads and stores go out over a single-outstanding request/acknowledge data-memory port with a cycle timeout. The stage then issues a one-cycle register-file write pulse for results that need writeback.

## Interface
- DATA_W, 32, data and ALU-result width
- ADDR_W, 16, memory address width; address = alu_result[ADDR_W-1:0]
- MEM_TIMEOUT, 15, max ACCESS cycles without mem_ack before abort (1..255)
- Clocking and reset (already decided): one clock; reset is asynchronous and active-low.
- clock  in  1  rising-edge clock
- reset_n  in  1  asynchronous active-low reset
- ex_valid  in  1  execute stage presents a transaction
- ex_ready  out  1  stage can accept; transfer when ex_valid && ex_ready
- ex_op  in  2  00 ALU-writeback, 01 load, 10 store, 11 no-op (e.g. branch)
- alu_result  in  DATA_W  ALU output (result or effective address)
- store_data  in  DATA_W  store write data
- ex_rd  in  5  destination register
- mem_req  out  1  memory request, held until ack or timeout
- mem_we  out  1  1 = write (store), 0 = read
- mem_addr  out  ADDR_W  request address
- mem_wdata  out  DATA_W  store data
- mem_rdata  in  DATA_W  read data, valid when mem_ack=1
- mem_ack  in  1  one-cycle completion strobe
- wb_en  out  1  register-file write strobe
- wb_rd  out  5  write register
- wb_data  out  DATA_W  write data
- mem_err  out  1  one-cycle pulse on timeout abort

## Operation
- Operation capture: on a transfer, latch ex_op, alu_result, store_data and ex_rd into internal registers.
- State machine: IDLE, ACCESS, WB.
- IDLE:
  - ex_ready=1.
  - Transfer with op 00 -> WB.
  - Transfer with op 01/10 -> ACCESS.
  - Transfer with op 11 is accepted and dropped; stay in IDLE.
- ACCESS:
  - mem_req=1; mem_we=(op==10); mem_addr and mem_wdata come from the latched values.
  - On mem_ack: a load captures mem_rdata and goes to WB; a store goes to IDLE.
- ACCESS timeout:
  - An 8-bit counter is cleared on entry and increments each ACCESS cycle without ack.
  - When the counter reaches MEM_TIMEOUT-1 with no ack, pulse mem_err and go to IDLE; no writeback.
  - An ack in that same final cycle wins and no error is raised.
- WB:
  - wb_en=1 for exactly one cycle; wb_rd is the latched rd.
  - wb_data is the latched alu_result (op 00) or the captured rdata (op 01).
  - Next state is IDLE.
- Register 0: rd==0 suppresses wb_en, but the WB cycle still occurs.
- mem_ack outside ACCESS is ignored.
- ex_ready=0 in ACCESS and WB, so upstream must hold its transaction.

## Timing
- Reset values:
  - State IDLE, ex_ready=1.
  - mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0.
  - wb_en=0, wb_rd=0, wb_data=0, mem_err=0, counter=0.
- Output registration: all outputs except ex_ready are registered; ex_ready decodes state.
- ALU op: accepted at edge N; wb_en high during cycle N+1; next accept at edge N+2.
- Load: accepted at edge N; mem_req high from cycle N+1. If ack is sampled at edge M, wb_en is high during cycle M+1 and the stage returns to IDLE at M+2.
- Store: ack at edge M makes mem_req low and ex_ready high from cycle M+1.
- Zero-wait memory: ack in the first ACCESS cycle gives a load latency of 3 cycles from accept to IDLE.
- Timeout: mem_req stays high for exactly MEM_TIMEOUT cycles; mem_err is high in the following cycle, together with ex_ready=1.
- Reset mid-transaction:
  - Asynchronous assertion drops mem_req and wb_en immediately.
  - The transaction is lost.
  - There is no writeback after release.

## Test plan
- Reset: hold reset_n=0 with random inputs -> all outputs at reset values, ex_ready=1; release -> idle, no strobes.
- ALU writeback: op 00, alu_result=0x0000_002A, rd=5 -> wb_en one cycle, wb_rd=5, wb_data=0x2A, next cycle ex_ready=1; same with rd=0 -> wb_en never asserts.
- Load with wait states: op 01, alu_result=0x0000_1234, memory acks after 3 cycles with rdata=0xDEAD_BEEF -> mem_req high 3 cycles, mem_addr=0x1234, mem_we=0, wb_data=0xDEADBEEF one cycle later.
- Store: op 10, alu_result=0x40, store_data=0x55AA55AA, rd=7, ack in first cycle -> mem_we=1, mem_wdata=0x55AA55AA, no wb_en, ex_ready back after 2 cycles.
- Timeout: load with mem_ack tied 0, MEM_TIMEOUT=15 -> mem_req high exactly 15 cycles, one mem_err pulse, no wb_en; repeat with ack in cycle 15 -> normal writeback, no mem_err.
- Backpressure/reset abort: hold ex_valid during a load -> upstream values are not re-accepted until IDLE; assert reset_n=0 mid-ACCESS -> mem_req drops asynchronously, no wb_en after release.
